// File: rtl/csi_raw10_unpack.sv
// csi_raw10_unpack: RAW10 payload unpacker behind the CSI-2 packet handler.
// Turns 16-bit payload words into 10-bit pixel pairs with per-line stats.
module csi_raw10_unpack #(
    parameter int CNT_W     = 16,
    parameter bit BYTE_SWAP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      din,
    input  logic             din_valid,
    input  logic             fr_active,
    output logic [19:0]      pix_out,
    output logic             pix_valid,
    output logic             sol,
    output logic             eol,
    output logic [CNT_W-1:0] pix_count,
    output logic             err_trunc
);

    typedef enum logic [2:0] {
        PH0,
        PH1,
        PH2,
        PH3,
        PH4
    } phase_t;

    localparam logic [CNT_W:0] PIX_PER_GRP = 4;

    phase_t            phase;
    phase_t            phase_nx;
    phase_t            cur_ph;
    logic              fr_q;
    logic [3:0][7:0]   grp;
    logic [3:0][7:0]   grp_nx;
    logic [3:0][7:0]   cb;
    logic [7:0]        cb4;
    logic              done;
    logic              accept;
    logic              rise;
    logic              fall;
    logic [7:0]        b_e;
    logic [7:0]        b_l;
    logic [39:0]       pix4;
    logic [19:0]       pend;
    logic              pend_v;
    logic              first_q;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W:0]    acc_sum;
    logic [CNT_W-1:0]  acc_sat;

    assign accept  = din_valid & fr_active;
    assign rise    = fr_active & ~fr_q;
    assign fall    = ~fr_active & fr_q;
    assign b_e     = BYTE_SWAP ? din[15:8] : din[7:0];
    assign b_l     = BYTE_SWAP ? din[7:0]  : din[15:8];
    assign acc_sum = {1'b0, acc} + PIX_PER_GRP;
    assign acc_sat = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];

    // Phase sequencing and byte capture; a line start forces phase 0 at once.
    always_comb begin
        cur_ph   = rise ? PH0 : phase;
        phase_nx = cur_ph;
        grp_nx   = rise ? '0 : grp;
        cb       = grp;
        cb4      = 8'h00;
        done     = 1'b0;
        if (accept) begin
            unique case (cur_ph)
                PH0: begin
                    grp_nx[0] = b_e;
                    grp_nx[1] = b_l;
                    phase_nx  = PH1;
                end
                PH1: begin
                    grp_nx[2] = b_e;
                    grp_nx[3] = b_l;
                    phase_nx  = PH2;
                end
                PH2: begin
                    cb4       = b_e;
                    done      = 1'b1;
                    grp_nx[0] = b_l;
                    phase_nx  = PH3;
                end
                PH3: begin
                    grp_nx[1] = b_e;
                    grp_nx[2] = b_l;
                    phase_nx  = PH4;
                end
                PH4: begin
                    cb[3]    = b_e;
                    cb4      = b_l;
                    done     = 1'b1;
                    phase_nx = PH0;
                end
                default: phase_nx = PH0;
            endcase
        end
        if (fall) begin
            phase_nx = PH0;
            grp_nx   = '0;
        end
    end

    // Reassemble four pixels: MSBs from their own byte, LSBs from byte 4.
    always_comb begin
        pix4 = '0;
        for (int n = 0; n < 4; n++) begin
            pix4[10*n +: 10] = {cb[n], cb4[2*n +: 2]};
        end
    end

    // Phase, group bytes and line-active history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH0;
            grp   <= '0;
            fr_q  <= 1'b0;
        end else begin
            phase <= phase_nx;
            grp   <= grp_nx;
            fr_q  <= fr_active;
        end
    end

    // Pixel output: low pair at once, high pair one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
            sol       <= 1'b0;
            pend      <= '0;
            pend_v    <= 1'b0;
        end else begin
            sol <= 1'b0;
            if (done) begin
                pix_out   <= pix4[19:0];
                pix_valid <= 1'b1;
                sol       <= first_q;
                pend      <= pix4[39:20];
                pend_v    <= 1'b1;
            end else if (pend_v) begin
                pix_out   <= pend;
                pix_valid <= 1'b1;
                pend_v    <= 1'b0;
            end else begin
                pix_valid <= 1'b0;
            end
        end
    end

    // Per-line bookkeeping: first-pair flag, pixel count, end-of-line flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q   <= 1'b0;
            acc       <= '0;
            pix_count <= '0;
            eol       <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            if (rise) begin
                first_q <= 1'b1;
                acc     <= '0;
            end else if (done) begin
                first_q <= 1'b0;
                acc     <= acc_sat;
            end
            if (fall) begin
                pix_count <= acc;
            end
            eol       <= fall;
            err_trunc <= fall && (phase != PH0);
        end
    end

endmodule
